// File: rtl/latch_input_conditioner.sv
// Conditions bouncy En/D switches for a NAND D-latch: 2-flop sync, counter debounce,
// one-cycle registered change pulses per channel.
module latch_input_conditioner #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic En_raw,
  input  logic D_raw,
  output logic En,
  output logic D,
  output logic en_rise,
  output logic en_fall,
  output logic d_toggle
);

  logic d_rise, d_fall;

  debounce_chan #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_en (
    .clk_i   (clk),
    .rst_i   (rst),
    .raw_i   (En_raw),
    .level_o (En),
    .rise_o  (en_rise),
    .fall_o  (en_fall)
  );

  debounce_chan #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_d (
    .clk_i   (clk),
    .rst_i   (rst),
    .raw_i   (D_raw),
    .level_o (D),
    .rise_o  (d_rise),
    .fall_o  (d_fall)
  );

  // Rise and fall are mutually exclusive flops, so their OR cannot glitch.
  assign d_toggle = d_rise | d_fall;

endmodule

// One channel: synchroniser, debounce FSM and registered edge pulses.
module debounce_chan #(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  typedef enum logic {ST_STABLE, ST_COUNT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t               state_q;
  logic                 s1_q, s2_q, level_q, rise_q, fall_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STABLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ST_STABLE: begin
          if (s2_q != level_q) begin
            state_q <= ST_COUNT;
            cnt_q   <= CNT_ONE;
          end
        end
        ST_COUNT: begin
          // Any return to the current level throws away the partial count.
          if (s2_q == level_q) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= ~level_q;
            rise_q  <= ~level_q;
            fall_q  <= level_q;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_STABLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: tb/tb_latch_input_conditioner.sv
// Directed test-plan sequences plus random bouncy stimulus, checked every cycle
// against a run-length model of the debounce rules.
module tb_latch_input_conditioner;

  localparam int S = 4;

  logic clk = 1'b0;
  logic rst, En_raw, D_raw;
  logic En, D, en_rise, en_fall, d_toggle;

  int n_checks = 0;
  int n_errors = 0;
  string phase = "reset";

  latch_input_conditioner #(.STABLE_CYCLES(S), .CNT_WIDTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .En_raw   (En_raw),
    .D_raw    (D_raw),
    .En       (En),
    .D        (D),
    .en_rise  (en_rise),
    .en_fall  (en_fall),
    .d_toggle (d_toggle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t {En,D,rise,fall,tog} got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // Model: a channel's output flips once its synchronised input has disagreed
  // with it for S consecutive edges; the sync path is a plain two-edge delay.
  bit m_s1[2], m_s2[2], m_out[2], m_pulse[2];
  int run[2];

  always @(posedge clk) begin
    bit raw[2];
    raw[0] = En_raw;
    raw[1] = D_raw;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_s1[c] = 0; m_s2[c] = 0; m_out[c] = 0; m_pulse[c] = 0; run[c] = 0;
      end else begin
        m_pulse[c] = 0;
        run[c] = (m_s2[c] != m_out[c]) ? run[c] + 1 : 0;
        if (run[c] == S) begin
          m_out[c]   = ~m_out[c];
          m_pulse[c] = 1;
          run[c]     = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
    end
  end

  always @(negedge clk) begin
    check(phase, {En, D, en_rise, en_fall, d_toggle},
          {m_out[0], m_out[1], m_pulse[0] & m_out[0], m_pulse[0] & ~m_out[0], m_pulse[1]});
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_en(input int n);
    En_raw = 1'b1; hold(n);
    En_raw = 1'b0; hold(10);
  endtask

  initial begin
    rst = 1'b1; En_raw = 1'b1; D_raw = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(10);

    phase = "clean_step";
    D_raw = 1'b0; hold(8);
    D_raw = 1'b1; hold(8);

    phase = "bounce_reject";
    En_raw = 1'b0; hold(8);
    pulse_en(S - 1);
    pulse_en(S);
    pulse_en(1);

    phase = "restart";
    En_raw = 1'b1; hold(2);
    En_raw = 1'b0; hold(1);
    En_raw = 1'b1; hold(10);
    En_raw = 1'b0; hold(8);

    phase = "simultaneous";
    D_raw = 1'b0; hold(8);
    En_raw = 1'b1; D_raw = 1'b1; hold(8);
    En_raw = 1'b0; D_raw = 1'b0; hold(8);

    phase = "reset_mid";
    D_raw = 1'b1; hold(3);
    rst = 1'b1; hold(1);
    rst = 1'b0; hold(8);
    rst = 1'b1; hold(2);
    rst = 1'b0; hold(8);

    phase = "random";
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        hold($urandom_range(1, 2));
        rst = 1'b0;
      end else begin
        En_raw = 1'($urandom_range(0, 1));
        D_raw  = 1'($urandom_range(0, 1));
        hold($urandom_range(1, 2 * S));
      end
    end

    hold(2);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
